// File: rtl/vermibus_arbiter_pkg.sv
// Shared types and constants for the Vermibus arbiter.
// Holds the FSM state enum, bus widths, the default timeout read word
// and a helper for index widths.
package vermibus_arbiter_pkg;

  localparam int unsigned WORD_WIDTH   = 32;
  localparam int unsigned STROBE_WIDTH = 4;

  // Word handed back when the watchdog forces a response.
  localparam logic [WORD_WIDTH-1:0] TIMEOUT_RDATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Width of a requester index; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vermibus_rr_pick.sv
// Round-robin selector.
// Ports: valid     - per-requester valid
//        last_grant - index served most recently
//        any       - at least one valid is set
//        pick      - first valid index searching from last_grant+1 (mod N)
module vermibus_rr_pick
  import vermibus_arbiter_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned GW = idx_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [GW-1:0] last_grant,
  output logic          any,
  output logic [GW-1:0] pick
);

  logic [GW-1:0] idx;

  // Walk the distances from farthest to nearest so the nearest valid
  // requester after last_grant is the one left in pick.
  always_comb begin
    any  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int k = N; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % N);
      if (valid[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/vermibus_arbiter.sv
// Shares one Vermibus target between N requesters with round-robin grant,
// the grant held from acceptance until the target answers, and a response
// watchdog that forces a reply from a silent target.
// Ports: clk, reset (async, active-low)
//        req_*  - requester side (valid/address/wstrobe/wdata in, ready/rdata out)
//        tgt_*  - target side (valid/address/wstrobe/wdata out, ready/rdata in)
//        grant  - current or last granted requester
//        timeout_flag - sticky, set on any watchdog response
module vermibus_arbiter
  import vermibus_arbiter_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned TIMEOUT = 256,
  parameter logic [WORD_WIDTH-1:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEFAULT,
  localparam int unsigned GW = idx_width(N)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N-1:0]                        req_valid,
  input  logic [N-1:0][WORD_WIDTH-1:0]        req_address,
  input  logic [N-1:0][STROBE_WIDTH-1:0]      req_wstrobe,
  input  logic [N-1:0][WORD_WIDTH-1:0]        req_wdata,
  output logic [N-1:0]                        req_ready,
  output logic [WORD_WIDTH-1:0]               req_rdata,
  output logic                                tgt_valid,
  output logic [WORD_WIDTH-1:0]               tgt_address,
  output logic [STROBE_WIDTH-1:0]             tgt_wstrobe,
  output logic [WORD_WIDTH-1:0]               tgt_wdata,
  input  logic                                tgt_ready,
  input  logic [WORD_WIDTH-1:0]               tgt_rdata,
  output logic [GW-1:0]                       grant,
  output logic                                timeout_flag
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_e        state, state_d;
  logic [GW-1:0] grant_d;
  logic [GW-1:0] last_grant, last_grant_d;
  logic [CW-1:0] wd_cnt, wd_cnt_d;
  logic          timeout_flag_d;

  logic          rr_any;
  logic [GW-1:0] rr_pick;
  logic          busy, cur_valid, wd_fire;

  vermibus_rr_pick #(.N(N)) u_rr_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .any        (rr_any),
    .pick       (rr_pick)
  );

  // Target-side mux and requester-side response; combinational passthrough.
  always_comb begin
    busy      = (state == BUSY);
    cur_valid = req_valid[grant];
    wd_fire   = busy && cur_valid && !tgt_ready &&
                (TIMEOUT != 0) && (wd_cnt == CNT_LIMIT);

    tgt_valid   = busy && cur_valid && !wd_fire;
    tgt_address = req_address[grant];
    tgt_wstrobe = req_wstrobe[grant];
    tgt_wdata   = req_wdata[grant];

    req_ready = '0;
    if (busy && cur_valid && (tgt_ready || wd_fire)) begin
      req_ready[grant] = 1'b1;
    end
    req_rdata = wd_fire ? TIMEOUT_RDATA : tgt_rdata;
  end

  // Next-state, grant bookkeeping and watchdog.
  always_comb begin
    state_d        = state;
    grant_d        = grant;
    last_grant_d   = last_grant;
    wd_cnt_d       = wd_cnt;
    timeout_flag_d = timeout_flag;

    case (state)
      IDLE: begin
        wd_cnt_d = '0;
        if (rr_any) begin
          grant_d = rr_pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!cur_valid) begin
          // Requester withdrew: abandon without ready, keep rotation position.
          state_d  = IDLE;
          wd_cnt_d = '0;
        end else if (tgt_ready || wd_fire) begin
          last_grant_d = grant;
          state_d      = IDLE;
          wd_cnt_d     = '0;
          if (wd_fire) begin
            timeout_flag_d = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (wd_cnt != CNT_MAX)) begin
          wd_cnt_d = wd_cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= GW'(N - 1);
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_d;
      grant        <= grant_d;
      last_grant   <= last_grant_d;
      wd_cnt       <= wd_cnt_d;
      timeout_flag <= timeout_flag_d;
    end
  end

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Self-checking bench for vermibus_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_vermibus_arbiter;
  import vermibus_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TO = 4;
  localparam int GW = $clog2(N);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req_valid;
  logic [N-1:0][31:0]    req_address;
  logic [N-1:0][3:0]     req_wstrobe;
  logic [N-1:0][31:0]    req_wdata;
  logic [N-1:0]          req_ready;
  logic [31:0]           req_rdata;
  logic                  tgt_valid;
  logic [31:0]           tgt_address;
  logic [3:0]            tgt_wstrobe;
  logic [31:0]           tgt_wdata;
  logic                  tgt_ready;
  logic [31:0]           tgt_rdata;
  logic [GW-1:0]         grant;
  logic                  timeout_flag;

  always #5 clk = ~clk;

  vermibus_arbiter #(.N(N), .TIMEOUT(TO), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_address  (req_address),
    .req_wstrobe  (req_wstrobe),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .req_rdata    (req_rdata),
    .tgt_valid    (tgt_valid),
    .tgt_address  (tgt_address),
    .tgt_wstrobe  (tgt_wstrobe),
    .tgt_wdata    (tgt_wdata),
    .tgt_ready    (tgt_ready),
    .tgt_rdata    (tgt_rdata),
    .grant        (grant),
    .timeout_flag (timeout_flag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the bus (-1 = free), how long the target has been silent,
  // who was last served, last granted index, sticky timeout.
  int m_owner, m_silent, m_last, m_grant;
  bit m_flag;

  logic [N-1:0] seen_ready;
  logic [31:0]  seen_rdata;
  int           served_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_silent = 0;
    m_last   = N - 1;
    m_grant  = 0;
    m_flag   = 1'b0;
  endtask

  // One clock cycle; called just after a falling edge with inputs driven.
  task automatic cycle();
    bit v, fire, found;
    logic [N-1:0] exp_rdy;
    #1;
    v = 1'b0; fire = 1'b0; exp_rdy = '0;
    if (m_owner >= 0) begin
      v    = req_valid[m_owner];
      fire = v && !tgt_ready && (m_silent == TO - 1);
      if (v && (tgt_ready || fire)) exp_rdy[m_owner] = 1'b1;
    end
    check("tgt_valid", 32'(tgt_valid), 32'(v && !fire));
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != '0)
      check("req_rdata", req_rdata, fire ? 32'hDEADBEEF : tgt_rdata);
    if (v && !fire) begin
      check("tgt_address", tgt_address, req_address[m_owner]);
      check("tgt_wstrobe", 32'(tgt_wstrobe), 32'(req_wstrobe[m_owner]));
      check("tgt_wdata", tgt_wdata, req_wdata[m_owner]);
    end
    seen_ready = req_ready;
    seen_rdata = req_rdata;
    if (exp_rdy != '0) served_q.push_back(m_owner);

    @(posedge clk);
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (!found && req_valid[i]) begin
          found    = 1'b1;
          m_owner  = i;
          m_grant  = i;
          m_silent = 0;
        end
      end
    end else if (!v) begin
      m_owner = -1;
    end else if (tgt_ready || fire) begin
      m_last  = m_owner;
      m_owner = -1;
      if (fire) m_flag = 1'b1;
    end else begin
      m_silent++;
    end
    #1;
    check("grant", 32'(grant), 32'(m_grant));
    check("timeout_flag", 32'(timeout_flag), 32'(m_flag));
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
    req_address[i] = a;
    req_wstrobe[i] = s;
    req_wdata[i]   = d;
  endtask

  bit [N-1:0] act;
  int silent_left;

  initial begin
    reset = 1'b0;
    req_valid = '0; req_address = '0; req_wstrobe = '0; req_wdata = '0;
    tgt_ready = 1'b0; tgt_rdata = '0;
    model_reset();
    #1;
    check("rst_tgt_valid", 32'(tgt_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_flag", 32'(timeout_flag), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Contention: req0 and req1 always valid, target always ready.
    served_q.delete();
    req_valid = 3'b011; tgt_ready = 1'b1;
    set_req(0, 32'h20, 4'h0, 32'h0); set_req(1, 32'h24, 4'h0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      tgt_rdata = 32'h1000 + 32'(c);
      cycle();
    end
    check("contend_count", 32'(served_q.size()), 32'd4);
    if (served_q.size() == 4) begin
      check("contend_g0", 32'(served_q[0]), 32'd0);
      check("contend_g1", 32'(served_q[1]), 32'd1);
      check("contend_g2", 32'(served_q[2]), 32'd0);
      check("contend_g3", 32'(served_q[3]), 32'd1);
    end
    req_valid = '0; tgt_ready = 1'b0;
    cycle();

    // Single read: target answers one cycle after tgt_valid.
    set_req(0, 32'h0000_0010, 4'h0, 32'h0);
    req_valid = 3'b001;
    cycle();
    check("rd_no_early_ready", 32'(seen_ready), 32'd0);
    cycle();
    check("rd_busy_no_ready", 32'(seen_ready), 32'd0);
    tgt_ready = 1'b1; tgt_rdata = 32'hA5A5_0010;
    cycle();
    check("rd_ready", 32'(seen_ready), 32'b001);
    check("rd_rdata", seen_rdata, 32'hA5A5_0010);
    req_valid = '0; tgt_ready = 1'b0;
    cycle();

    // Write passthrough from requester 1.
    set_req(1, 32'h0000_0100, 4'b0011, 32'hCAFE_F00D);
    req_valid = 3'b010;
    cycle(); cycle(); cycle();
    check("wr_addr", tgt_address, 32'h0000_0100);
    tgt_ready = 1'b1;
    cycle();
    check("wr_ready", 32'(seen_ready), 32'b010);
    req_valid = '0; tgt_ready = 1'b0;
    cycle();

    // Target answers exactly on the watchdog limit cycle.
    set_req(0, 32'h40, 4'h0, 32'h0);
    req_valid = 3'b001; tgt_rdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) cycle();
    tgt_ready = 1'b1;
    cycle();
    check("limit_rdata", seen_rdata, 32'h1234_5678);
    check("limit_flag", 32'(timeout_flag), 32'd0);
    req_valid = '0; tgt_ready = 1'b0;
    cycle();

    // Silent target: forced response on the 4th busy cycle.
    set_req(2, 32'h80, 4'hF, 32'h5555_AAAA);
    req_valid = 3'b100;
    for (int c = 0; c < 4; c++) cycle();
    check("to_no_early", 32'(seen_ready), 32'd0);
    cycle();
    check("to_ready", 32'(seen_ready), 32'b100);
    check("to_rdata", seen_rdata, 32'hDEADBEEF);
    check("to_flag", 32'(timeout_flag), 32'd1);
    req_valid = 3'b001; tgt_ready = 1'b1;
    cycle(); cycle();
    check("to_flag_sticky", 32'(timeout_flag), 32'd1);
    req_valid = '0; tgt_ready = 1'b0;
    cycle();

    // Reset while a transfer is in flight.
    req_valid = 3'b010;
    cycle(); cycle();
    reset = 1'b0;
    #1;
    check("mid_rst_tgt_valid", 32'(tgt_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_flag", 32'(timeout_flag), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 3'b011; tgt_ready = 1'b1;
    served_q.delete();
    cycle(); cycle();
    check("post_rst_first", served_q.size() > 0 ? 32'(served_q[0]) : 32'hFFFF_FFFF, 32'd0);
    req_valid = '0; tgt_ready = 1'b0;
    cycle();

    // Random traffic with occasional withdrawals and silent stretches.
    act = '0; silent_left = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (act[i] && $urandom_range(99) < 3) act[i] = 1'b0;
        else if (!act[i] && $urandom_range(99) < 40) begin
          act[i] = 1'b1;
          set_req(i, $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom), $urandom);
        end
      end
      req_valid = act;
      if (silent_left > 0) begin
        silent_left--;
        tgt_ready = 1'b0;
      end else begin
        if ($urandom_range(99) < 4) silent_left = 6;
        tgt_ready = ($urandom_range(99) < 50);
      end
      tgt_rdata = $urandom;
      cycle();
      act = act & ~seen_ready;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vermibus_arbiter.md
Name: vermibus_arbiter

Overview:
- Shares one Vermibus target (typically the Vermimory RAM) between N requesters, e.g. the Vermicel CPU and a DMA or debug loader.
- Round-robin grant, with the grant locked from acceptance until the target completes.
- Includes a response watchdog, so a silent target cannot hang the system.
- Sits between the requester buses and the device decode in benchmark and SoC tops.

Parameters:
- N, 2, number of requesters (2..8).
- TIMEOUT, 256, maximum BUSY cycles without target ready before a forced response; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hDEADBEEF, rdata returned on a forced (timeout) response.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N  per-requester valid.
- req_address  in  N x 32  per-requester byte address.
- req_wstrobe  in  N x 4  per-requester byte write strobes; all-zero means read.
- req_wdata  in  N x 32  per-requester write data.
- req_ready  out  N  per-requester ready (at most one bit set).
- req_rdata  out  32  read data, broadcast to all requesters.
- tgt_valid  out  1  valid to the target.
- tgt_address  out  32  address to the target.
- tgt_wstrobe  out  4  write strobes to the target.
- tgt_wdata  out  32  write data to the target.
- tgt_ready  in  1  ready from the target.
- tgt_rdata  in  32  read data from the target.
- grant  out  $clog2(N)  index of the current or last granted requester.
- timeout_flag  out  1  sticky; set on any watchdog response.

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE, grant=0, last_grant=N-1 so requester 0 wins first.
  - Watchdog counter=0, timeout_flag=0.
  - tgt_valid=0 and req_ready=0 immediately.
- Reset mid-transaction: the in-flight access is abandoned with no ready; the requester re-issues after reset.
- Bus rule: a requester holds valid, address, wstrobe and wdata stable until it sees its ready bit. A transfer completes in the cycle where valid and ready are both 1.
- IDLE:
  - tgt_valid=0, req_ready=0.
  - If any req_valid is set, the requester selected by round-robin is registered into grant and state goes to BUSY.
  - Round-robin search starts at (last_grant+1) mod N and takes the first index with valid set.
  - If no req_valid is set, stay IDLE.
- BUSY:
  - tgt_valid=req_valid[grant]; tgt_address, tgt_wstrobe and tgt_wdata are muxed from grant.
  - req_ready[grant]=tgt_ready, combinational passthrough; req_rdata=tgt_rdata.
  - On tgt_ready=1: last_grant<=grant, counter<=0, next state IDLE.
  - Arbitration overhead is one cycle per transfer. Minimum latency from req_valid to req_ready is 1 cycle plus the target latency.
- Watchdog (TIMEOUT>0):
  - The counter increments each BUSY cycle with tgt_ready=0.
  - When counter==TIMEOUT-1 and tgt_ready=0, the arbiter forces req_ready[grant]=1 and req_rdata=TIMEOUT_RDATA in that cycle.
  - tgt_valid=0 in that same cycle.
  - timeout_flag<=1 (sticky until reset); last_grant<=grant; state goes to IDLE.
  - A write that times out is dropped.
  - If tgt_ready=1 in the same cycle the counter reaches its limit, the genuine response wins and no flag is set.
- Protocol violation (req_valid[grant] drops in BUSY before ready):
  - tgt_valid follows it to 0.
  - Return to IDLE next cycle; no ready is given and last_grant is unchanged.
- Outputs not granted: req_ready bits for non-granted requesters are always 0.
- Widths:
  - The watchdog counter is $clog2(TIMEOUT+1) bits and never wraps; it is cleared on entering IDLE.
  - The round-robin index wraps mod N.
- Simultaneous requests: all requesters valid every cycle gives a grant order of 0,1,..,N-1,0,...; no requester waits more than N transfers.

Decomposition:
- Package vermibus_arbiter_pkg holds:
  - state enum {IDLE, BUSY}
  - WORD_WIDTH=32 and STROBE_WIDTH=4
  - TIMEOUT_RDATA default constant
- Sub-module vermibus_rr_pick (combinational, parameter N): inputs valid[N] and last_grant; outputs any and pick.
- The FSM, mux and watchdog stay in the top module.

Test Plan:
- Single requester, N=2: req0 reads 0x0000_0010 with the target ready 1 cycle after tgt_valid. Expect grant=0 and req_ready[0] 2 cycles after req_valid, with rdata equal to the target word.
- Contention: req0 and req1 valid continuously, target always ready. Expect grant sequence 0,1,0,1 and each ready pulse 1 cycle wide, alternating.
- Write passthrough: req1 writes wdata=0xCAFE_F00D, wstrobe=4'b0011, address 0x0000_0100. Expect tgt_* to match exactly while BUSY; req0 ready stays 0.
- Timeout, TIMEOUT=4, target never ready: expect req_ready[grant]=1 on the 4th BUSY cycle, rdata=0xDEADBEEF and timeout_flag=1. The flag stays 1 across the next normal transfer.
- Ready on the limit cycle: tgt_ready=1 exactly on the 4th BUSY cycle. Expect the genuine tgt_rdata and timeout_flag=0.
- Mid-transaction reset: assert reset=0 in BUSY. Expect tgt_valid and req_ready to be 0 in the same cycle; after release, state is IDLE and the first grant goes to requester 0.
